// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM stream reader.
//   state_e      : engine state (IDLE, RUN, DRAIN)
//   SKID_DEPTH   : entries in the output skid buffer
//   addr_width() : address width for a given BRAM depth
package bram_stream_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int SKID_DEPTH = 2;

   function automatic int addr_width(input int d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

endpackage

// File: rtl/bram_stream_reader_skid.sv
// Two-entry valid/ready skid buffer for the stream reader output.
//   CLK, nRST      : clock, async active-low reset (clears entries and occupancy)
//   push/push_data : write one entry (caller guarantees space)
//   pop            : consumer took the head entry this cycle
//   head_data      : current head entry
//   valid          : at least one entry held
//   occupancy      : entries held (0..2), used by the read credit check
module bram_stream_reader_skid
   import bram_stream_reader_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output logic          valid,
   output logic [1:0]    occupancy
);

   logic [SKID_DEPTH-1:0][DW-1:0] ent_q, ent_d;
   logic [1:0]                    occ_q, occ_d;
   logic [1:0]                    occ_after_pop;
   logic                          pop_ok;

   always_comb begin
      ent_d         = ent_q;
      pop_ok        = pop & (occ_q != 2'd0);
      occ_after_pop = occ_q - {1'b0, pop_ok};
      if (pop_ok) begin
         ent_d[0] = ent_q[1];
      end
      // New entry lands behind whatever survives this cycle's pop.
      if (push) begin
         ent_d[occ_after_pop[0]] = push_data;
      end
      occ_d = occ_after_pop + {1'b0, push};
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ent_q <= '0;
         occ_q <= 2'd0;
      end else begin
         ent_q <= ent_d;
         occ_q <= occ_d;
      end
   end

   assign head_data = ent_q[0];
   assign valid     = (occ_q != 2'd0);
   assign occupancy = occ_q;

endmodule

// File: rtl/bram_stream_reader.sv
// BRAM stream reader: accepts a (base, count) command, issues sequential
// BRAM reads (address modulo depth) and returns the words in order on a
// valid/ready stream, pulsing done once the last word has left.
// Ports: CLK, nRST (async active-low); start__ENA/start_base/start_count/
// start__RDY command; bram_read__ENA/bram_read_addr/bram_read__RDY and
// bram_dataOut (1-cycle latency) BRAM side; out__ENA/out_data/out__RDY
// output stream; done completion pulse.
// Optional macro BRAM_STREAM_READER_LAST_EN adds out_last, high with the
// final word of each command.
//
// state | meaning
// IDLE  | waiting for a command, start__RDY=1
// RUN   | issuing reads while words remain
// DRAIN | all reads issued, waiting for in-flight data and buffer to empty
module bram_stream_reader
   import bram_stream_reader_pkg::*;
#(
   parameter  int width = 4,
   parameter  int depth = 1024,
   localparam int AW    = addr_width(depth)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             start__ENA,
   input  logic [AW-1:0]    start_base,
   input  logic [AW:0]      start_count,
   output logic             start__RDY,
   output logic             bram_read__ENA,
   output logic [AW-1:0]    bram_read_addr,
   input  logic             bram_read__RDY,
   input  logic [width-1:0] bram_dataOut,
   output logic             out__ENA,
   output logic [width-1:0] out_data,
   input  logic             out__RDY,
   output logic             done
`ifdef BRAM_STREAM_READER_LAST_EN
  ,output logic             out_last
`endif
);

`ifdef BRAM_STREAM_READER_LAST_EN
   localparam int SW = width + 1;
`else
   localparam int SW = width;
`endif

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [AW:0]     remaining_q, remaining_d;
   logic            inflight_q, inflight_d;
   logic            done_q, done_d;
`ifdef BRAM_STREAM_READER_LAST_EN
   logic            inflight_last_q, inflight_last_d;
`endif

   logic            pop, issue, skid_valid;
   logic [1:0]      occ, credit_use;
   logic [SW-1:0]   push_data, head;

   always_comb begin
      pop = skid_valid & out__RDY;
      // Credit counts buffered plus in-flight words, less the one leaving now,
      // so a steady stream keeps one read per cycle without overflowing.
      credit_use     = occ + {1'b0, inflight_q} - {1'b0, pop};
      bram_read__ENA = (state_q == RUN) && (remaining_q != '0) && (credit_use < 2'd2);
      issue          = bram_read__ENA & bram_read__RDY;

      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      inflight_d  = issue;
      done_d      = 1'b0;
`ifdef BRAM_STREAM_READER_LAST_EN
      inflight_last_d = issue && (remaining_q == (AW+1)'(1));
`endif

      case (state_q)
         IDLE: begin
            if (start__ENA) begin
               if (start_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = RUN;
                  addr_d      = start_base;
                  remaining_d = start_count;
               end
            end
         end
         RUN: begin
            if (issue) begin
               addr_d      = (addr_q == AW'(depth - 1)) ? '0 : addr_q + AW'(1);
               remaining_d = remaining_q - (AW+1)'(1);
               if (remaining_q == (AW+1)'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Registered done lands in the cycle right after the last word leaves.
            if (!inflight_q && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
`ifdef BRAM_STREAM_READER_LAST_EN
         inflight_last_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         inflight_q  <= inflight_d;
         done_q      <= done_d;
`ifdef BRAM_STREAM_READER_LAST_EN
         inflight_last_q <= inflight_last_d;
`endif
      end
   end

`ifdef BRAM_STREAM_READER_LAST_EN
   assign push_data = {inflight_last_q, bram_dataOut};
   assign out_last  = head[width];
`else
   assign push_data = bram_dataOut;
`endif

   bram_stream_reader_skid #(.DW(SW)) u_skid (
      .CLK       (CLK),
      .nRST      (nRST),
      .push      (inflight_q),
      .push_data (push_data),
      .pop       (pop),
      .head_data (head),
      .valid     (skid_valid),
      .occupancy (occ)
   );

   assign start__RDY     = (state_q == IDLE);
   assign bram_read_addr = addr_q;
   assign out__ENA       = skid_valid;
   assign out_data       = head[width-1:0];
   assign done           = done_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

   localparam int W  = 4;
   localparam int D  = 1024;
   localparam int AW = 10;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          start__ENA;
   logic [AW-1:0] start_base;
   logic [AW:0]   start_count;
   logic          start__RDY;
   logic          bram_read__ENA;
   logic [AW-1:0] bram_addr;
   logic          bram_read__RDY;
   logic [W-1:0]  bram_dout;
   logic          out__ENA;
   logic [W-1:0]  out_data;
   logic          out__RDY;
   logic          done;
   logic          out_last;

   int vectors = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   bram_stream_reader #(.width(W), .depth(D)) dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .start__ENA     (start__ENA),
      .start_base     (start_base),
      .start_count    (start_count),
      .start__RDY     (start__RDY),
      .bram_read__ENA (bram_read__ENA),
      .bram_read_addr (bram_addr),
      .bram_read__RDY (bram_read__RDY),
      .bram_dataOut   (bram_dout),
      .out__ENA       (out__ENA),
      .out_data       (out_data),
      .out__RDY       (out__RDY),
      .done           (done)
`ifdef BRAM_STREAM_READER_LAST_EN
     ,.out_last       (out_last)
`endif
   );

`ifndef BRAM_STREAM_READER_LAST_EN
   assign out_last = 1'b0;
`endif

   function automatic logic [3:0] ram_val(input int a);
      return 4'(a * 3 + 1);
   endfunction

   // BRAM model: registered read, one cycle latency.
   always @(posedge CLK) begin
      if (bram_read__ENA && bram_read__RDY) bram_dout <= ram_val(int'(bram_addr));
   end

   int iss_addr[$];
   int iss_cyc[$];
   int od[$];
   int oc[$];
   int ol[$];
   int ena_addr[256];
   int done_cyc;
   int done_count;
   int stall_err;
   logic rdy_at_done;

   // Drives one command and records what happens cycle by cycle (c=0 is the start cycle).
   task automatic run_cmd(input int base, input int count, input int rdy_mode,
                          input int stall_lo, input int stall_hi);
      bit prev_stall;
      logic [3:0] prev_data;
      iss_addr.delete(); iss_cyc.delete(); od.delete(); oc.delete(); ol.delete();
      for (int i = 0; i < 256; i++) ena_addr[i] = -1;
      done_cyc = -1; done_count = 0; stall_err = 0; prev_stall = 0; prev_data = '0;
      rdy_at_done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge CLK); #1;
         start__ENA     = (c == 0);
         start_base     = AW'(base);
         start_count    = (AW+1)'(count);
         out__RDY       = (rdy_mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
         bram_read__RDY = !(c >= stall_lo && c <= stall_hi);
         #1;
         ena_addr[c] = bram_read__ENA ? int'(bram_addr) : -1;
         if (bram_read__ENA && bram_read__RDY) begin
            iss_addr.push_back(int'(bram_addr)); iss_cyc.push_back(c);
         end
         if (prev_stall && (!out__ENA || out_data !== prev_data)) stall_err++;
         prev_stall = out__ENA && !out__RDY;
         prev_data  = out_data;
         if (out__ENA && out__RDY) begin
            od.push_back(int'(out_data)); oc.push_back(c); ol.push_back(int'(out_last));
         end
         if (done === 1'b1) begin
            done_count++;
            if (done_cyc < 0) begin done_cyc = c; rdy_at_done = start__RDY; end
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
      end
      start__ENA = 1'b0; out__RDY = 1'b1; bram_read__RDY = 1'b1;
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic test_reset();
      vectors++;
      if (start__RDY !== 1'b1 || bram_read__ENA !== 1'b0 || bram_addr !== '0 ||
          out__ENA !== 1'b0 || out_data !== '0 || done !== 1'b0 || out_last !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy=%b ena=%b addr=%0d oena=%b data=%0d done=%b last=%b, want 1 0 0 0 0 0 0",
                  start__RDY, bram_read__ENA, bram_addr, out__ENA, out_data, done, out_last);
      end
   endtask

   task automatic test_basic();
      run_cmd(5, 4, 0, -1, -1);
      vectors++;
      if (iss_addr.size() !== 4 || od.size() !== 4) begin
         miscompares++;
         $display("FAIL basic_counts: issues=%0d words=%0d, want 4 4", iss_addr.size(), od.size());
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (qget(iss_addr, i) !== 5 + i || qget(iss_cyc, i) !== 1 + i) begin
            miscompares++;
            $display("FAIL basic_issue[%0d]: addr=%0d cyc=%0d, want %0d %0d",
                     i, qget(iss_addr, i), qget(iss_cyc, i), 5 + i, 1 + i);
         end
         vectors++;
         if (qget(od, i) !== int'(ram_val(5 + i))) begin
            miscompares++;
            $display("FAIL basic_data[%0d]: got %0d, want %0d", i, qget(od, i), ram_val(5 + i));
         end
`ifdef BRAM_STREAM_READER_LAST_EN
         vectors++;
         if (qget(ol, i) !== ((i == 3) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL basic_last[%0d]: got %0d, want %0d", i, qget(ol, i), (i == 3) ? 1 : 0);
         end
`endif
      end
      vectors++;
      if (qget(oc, 0) !== 3 || qget(oc, 3) !== 6) begin
         miscompares++;
         $display("FAIL basic_out_timing: first=%0d last=%0d, want 3 6", qget(oc, 0), qget(oc, 3));
      end
      vectors++;
      if (done_cyc !== 7 || done_count !== 1) begin
         miscompares++;
         $display("FAIL basic_done: cyc=%0d pulses=%0d, want 7 1", done_cyc, done_count);
      end
   endtask

   task automatic test_count_zero();
      int any_ena;
      run_cmd(40, 0, 0, -1, -1);
      any_ena = 0;
      for (int c = 0; c < 8; c++) if (ena_addr[c] != -1) any_ena++;
      vectors++;
      if (any_ena !== 0 || od.size() !== 0) begin
         miscompares++;
         $display("FAIL zero_no_reads: ena_cycles=%0d words=%0d, want 0 0", any_ena, od.size());
      end
      vectors++;
      if (done_cyc !== 1 || done_count !== 1 || rdy_at_done !== 1'b1) begin
         miscompares++;
         $display("FAIL zero_done: cyc=%0d pulses=%0d rdy=%b, want 1 1 1", done_cyc, done_count, rdy_at_done);
      end
   endtask

   task automatic test_wrap();
      int exp_a[4];
      exp_a = '{1022, 1023, 0, 1};
      run_cmd(1022, 4, 0, -1, -1);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (qget(iss_addr, i) !== exp_a[i] || qget(od, i) !== int'(ram_val(exp_a[i]))) begin
            miscompares++;
            $display("FAIL wrap[%0d]: addr=%0d data=%0d, want %0d %0d",
                     i, qget(iss_addr, i), qget(od, i), exp_a[i], ram_val(exp_a[i]));
         end
      end
      vectors++;
      if (done_cyc !== 7 || od.size() !== 4) begin
         miscompares++;
         $display("FAIL wrap_done: cyc=%0d words=%0d, want 7 4", done_cyc, od.size());
      end
   endtask

   task automatic test_backpressure();
      run_cmd(100, 8, 1, -1, -1);
      vectors++;
      if (od.size() !== 8 || iss_addr.size() !== 8 || done_count !== 1) begin
         miscompares++;
         $display("FAIL bp_counts: words=%0d issues=%0d pulses=%0d, want 8 8 1",
                  od.size(), iss_addr.size(), done_count);
      end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (qget(od, i) !== int'(ram_val(100 + i)) || qget(iss_addr, i) !== 100 + i) begin
            miscompares++;
            $display("FAIL bp_word[%0d]: data=%0d addr=%0d, want %0d %0d",
                     i, qget(od, i), qget(iss_addr, i), ram_val(100 + i), 100 + i);
         end
`ifdef BRAM_STREAM_READER_LAST_EN
         vectors++;
         if (qget(ol, i) !== ((i == 7) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL bp_last[%0d]: got %0d, want %0d", i, qget(ol, i), (i == 7) ? 1 : 0);
         end
`endif
      end
      vectors++;
      if (stall_err !== 0) begin
         miscompares++;
         $display("FAIL bp_stable: unstable stall cycles=%0d, want 0", stall_err);
      end
   endtask

   task automatic test_bram_stall();
      run_cmd(200, 6, 0, 3, 5);
      for (int c = 3; c <= 5; c++) begin
         vectors++;
         if (ena_addr[c] !== 202) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: addr=%0d, want 202", c, ena_addr[c]);
         end
      end
      vectors++;
      if (qget(iss_cyc, 2) !== 6) begin
         miscompares++;
         $display("FAIL stall_resume: cyc=%0d, want 6", qget(iss_cyc, 2));
      end
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (qget(iss_addr, i) !== 200 + i || qget(od, i) !== int'(ram_val(200 + i))) begin
            miscompares++;
            $display("FAIL stall_word[%0d]: addr=%0d data=%0d, want %0d %0d",
                     i, qget(iss_addr, i), qget(od, i), 200 + i, ram_val(200 + i));
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int bad;
      @(posedge CLK); #1;
      start__ENA = 1'b1; start_base = AW'(300); start_count = (AW+1)'(8); out__RDY = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge CLK); #1;
         start__ENA = 1'b0;
      end
      #1;
      vectors++;
      if (out__ENA !== 1'b1 || bram_read__ENA !== 1'b0 || out_data !== ram_val(300)) begin
         miscompares++;
         $display("FAIL abort_prefill: oena=%b rena=%b data=%0d, want 1 0 %0d",
                  out__ENA, bram_read__ENA, out_data, ram_val(300));
      end
      nRST = 1'b0;
      #1;
      vectors++;
      if (out__ENA !== 1'b0 || bram_read__ENA !== 1'b0 || start__RDY !== 1'b1 || out_data !== '0) begin
         miscompares++;
         $display("FAIL abort_reset: oena=%b rena=%b rdy=%b data=%0d, want 0 0 1 0",
                  out__ENA, bram_read__ENA, start__RDY, out_data);
      end
      @(negedge CLK);
      nRST = 1'b1;
      out__RDY = 1'b1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge CLK); #2;
         if (done !== 1'b0 || out__ENA !== 1'b0) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL abort_no_done: bad cycles=%0d, want 0", bad);
      end
      run_cmd(8, 3, 0, -1, -1);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (qget(od, i) !== int'(ram_val(8 + i))) begin
            miscompares++;
            $display("FAIL after_reset_data[%0d]: got %0d, want %0d", i, qget(od, i), ram_val(8 + i));
         end
      end
      vectors++;
      if (done_cyc !== 6 || done_count !== 1) begin
         miscompares++;
         $display("FAIL after_reset_done: cyc=%0d pulses=%0d, want 6 1", done_cyc, done_count);
      end
   endtask

   initial begin
      nRST = 1'b0; start__ENA = 1'b0; start_base = '0; start_count = '0;
      bram_read__RDY = 1'b1; out__RDY = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      test_reset();
      @(negedge CLK);
      nRST = 1'b1;
      test_basic();
      test_count_zero();
      test_wrap();
      test_backpressure();
      test_bram_stall();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
